dev_bus_arbiter: RTL and testbench
==================================

# dev_bus_arbiter

Two-master arbiter for the device bus in front of the system bridge. Shares the single bridge port (address, write data, write enable) between the CPU data port (M0) and a secondary master such as a DMA or debug loader (M1). Each request runs as one registered, handshaked transaction; arbitration is round-robin, and accesses outside the two device windows are rejected without a bus cycle.

## Interface
- `DATA_W`, 32: address and data width.
- `TIMEOUT`, 15: number of BUSY cycles without `bus_rdy` before a forced error completion. Legal range 1..255.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `m0_req` in 1: M0 transaction request; held until `m0_ack`.
- `m0_addr` in DATA_W: M0 byte address.
- `m0_wd` in DATA_W: M0 write data.
- `m0_we` in 1: M0 write (1) or read (0).
- `m0_ack` out 1: one-cycle completion pulse.
- `m0_rd` out DATA_W: read data; valid while `m0_ack`=1.
- `m0_err` out 1: error flag; valid while `m0_ack`=1.
- `m1_req`, `m1_addr`, `m1_wd`, `m1_we`, `m1_ack`, `m1_rd`, `m1_err`: same as M0, for M1.
- `bus_req` out 1: a bus cycle is active.
- `bus_addr` out DATA_W: address to the bridge.
- `bus_wd` out DATA_W: write data to the bridge.
- `bus_we` out 1: write enable to the bridge; only ever asserted while `bus_req`=1.
- `bus_rd` in DATA_W: read data from the bridge.
- `bus_rdy` in 1: the device completes the current cycle.

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: a bus cycle is in flight.
  - REJECT: one cycle, error completion without a bus cycle.
- Eligible requester: `mX_req`=1 and `mX_ack` not currently high. This masks the requester that is being acknowledged in the same cycle.
- IDLE, one eligible requester: grant it.
- IDLE, both eligible: grant the master not granted last. `last_grant` resets to M1, so M0 wins the first tie.
- On grant, register the owner, address, write data and write enable, and update `last_grant`.
- Next state after a grant:
  - Address window hit, `addr[15:4]` = 12'h7F0 or 12'h7F1: BUSY.
  - Any other address: REJECT.
- BUSY:
  - `bus_req`=1; `bus_addr`, `bus_wd` and `bus_we` are driven from the registered copies.
  - On `bus_rdy`=1: capture `bus_rd` into the owner's `rd` on a read (writes give `rd`=0), pulse the owner's `ack`, and go to IDLE.
- REJECT: pulse the owner's `ack` with `err`=1 and `rd`=0, then go to IDLE.
- Changes to master inputs while a transaction is in flight have no effect; the latched copies are used.
- A request dropped before its `ack` still completes and still pulses `ack`.
- Reset mid-transaction: the cycle is abandoned, all outputs are cleared, and no `ack` is issued.

## Timing
- Reset values: state IDLE, all `ack`=0, `err`=0, `rd`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wd`=0, `last_grant`=M1.
- All outputs are registered; the bus outputs update on the grant edge.
- Zero-wait device (`bus_rdy`=1 in the first BUSY cycle): request sampled at edge N, `bus_req` high during cycle N+1, `ack` high during cycle N+2.
- Each extra wait cycle adds one cycle of latency.
- REJECT: `ack` high during cycle N+2, with `bus_req` never asserted.
- Back-to-back requests: the IDLE cycle that carries an `ack` can grant the other master. Sustained peak is one transaction per 2 cycles.
- `ack` is exactly one cycle wide.

## Configuration
- `DEV_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle with `bus_rdy`=0.
  - When the count reaches `TIMEOUT`, the transaction completes: `err`=1, `rd`=0, `bus_req` drops, next state IDLE.
  - If `bus_rdy` arrives in the same cycle the count is reached, it is a normal completion with `err`=0.
- `DEV_ARB_TIMEOUT_EN` not defined: BUSY waits indefinitely for `bus_rdy`, and `err` is asserted only on REJECT.

## Structure
- Shared package `dev_arb_pkg` contains:
  - the state encoding (IDLE/BUSY/REJECT);
  - window constants `DEV0_WIN`=12'h7F0 and `DEV1_WIN`=12'h7F1;
  - the owner encoding (M0=0, M1=1).
- Sub-module `dev_arb_rr`: two-input round-robin picker, consisting of the `last_grant` register plus the grant logic.
- The rest (state machine, latches, timeout counter) lives in the top module.

## Test plan
- M0 read of 0x00007F04, `bus_rd`=0xDEADBEEF, `bus_rdy`=1 immediately -> `bus_req` one cycle, `m0_ack` at N+2 with `m0_rd`=0xDEADBEEF and `m0_err`=0.
- M0 and M1 request together (both to 0x7F10), held for 4 transactions -> grant order M0, M1, M0, M1; each `ack` is one cycle; `bus_we` matches the owner.
- M1 write to 0x00001000 -> `bus_req` stays 0, `m1_ack` at N+2 with `m1_err`=1 and `m1_rd`=0.
- M0 write to 0x7F00, `bus_rdy` held low with `DEV_ARB_TIMEOUT_EN` and `TIMEOUT`=15 -> `m0_ack` with `m0_err`=1 after 15 BUSY cycles. Without the macro: no `ack` until `bus_rdy` rises.
- `reset_n` pulsed low during BUSY -> all outputs 0 immediately; after release, a pending M1 request is granted and completes normally.
- M0 drops `m0_req` and changes `m0_addr` mid-BUSY -> the original address is held on the bus, and `m0_ack` is still pulsed once.

Source files
------------

// File: rtl/dev_arb_pkg.sv
// ----------------------------------------------------------------------------
// dev_arb_pkg
// Shared types and constants for the two-master device bus arbiter.
//   state_e  : arbiter FSM encoding (IDLE / BUSY / REJECT)
//   owner_e  : transaction owner (M0 = CPU data port, M1 = secondary master)
//   DEV0_WIN / DEV1_WIN : addr[15:4] values of the two device windows
//   win_hit()  : window decode helper
// ----------------------------------------------------------------------------
package dev_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_REJECT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam logic [11:0] DEV0_WIN = 12'h7F0;
    localparam logic [11:0] DEV1_WIN = 12'h7F1;

    // True when addr[15:4] selects one of the two device windows.
    function automatic logic win_hit(input logic [11:0] page);
        return (page == DEV0_WIN) || (page == DEV1_WIN);
    endfunction

endpackage

// File: rtl/dev_arb_rr.sv
// ----------------------------------------------------------------------------
// dev_arb_rr
// Two-input round-robin picker: holds last_grant and selects the winner.
//   clk, reset_n : clock, async active-low reset (last_grant resets to M1)
//   req0_i/req1_i: eligible requests from M0 / M1
//   take_i       : the pick is consumed this cycle, update last_grant
//   gnt_vld_o    : at least one request present
//   gnt_owner_o  : selected master
// ----------------------------------------------------------------------------
module dev_arb_rr
    import dev_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   req0_i,
    input  logic   req1_i,
    input  logic   take_i,
    output logic   gnt_vld_o,
    output owner_e gnt_owner_o
);

    owner_e last_q;

    always_comb begin
        gnt_vld_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            // Tie: favour the master that did not win last time.
            gnt_owner_o = (last_q == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req0_i) begin
            gnt_owner_o = OWN_M0;
        end else begin
            gnt_owner_o = OWN_M1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= OWN_M1;
        end else if (take_i && gnt_vld_o) begin
            last_q <= gnt_owner_o;
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// ----------------------------------------------------------------------------
// dev_bus_arbiter
// Shares one bridge port between M0 (CPU data) and M1 (DMA / debug loader).
// Each request becomes one registered transaction; out-of-window accesses
// complete with an error and no bus cycle.
//   clk, reset_n            : clock, async active-low reset
//   mX_req/addr/wd/we       : master request (held until mX_ack)
//   mX_ack/rd/err           : one-cycle completion pulse with read data/error
//   bus_req/addr/wd/we      : registered bridge request
//   bus_rd, bus_rdy         : bridge read data and completion
// Optional: define DEV_ARB_TIMEOUT_EN to force an error completion after
// TIMEOUT BUSY cycles without bus_rdy.
// ----------------------------------------------------------------------------
module dev_bus_arbiter
    import dev_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m0_we,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    input  logic              m1_we,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd,
    output logic              m1_err,
    output logic              bus_req,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wd,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rd,
    input  logic              bus_rdy
);

    state_e                   state_q, state_d;
    owner_e                   owner_q, owner_d;
    logic [DATA_W-1:0]        addr_q, addr_d;
    logic [DATA_W-1:0]        wd_q, wd_d;
    logic                     we_q, we_d;
    logic                     bus_req_q, bus_req_d;
    logic                     bus_we_q, bus_we_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0]               err_q, err_d;
    logic [1:0][DATA_W-1:0]   rd_q, rd_d;

`ifdef DEV_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
    logic [7:0]               cnt_q, cnt_d;
`endif

    logic                     elig0, elig1;
    logic                     gnt_vld, rr_take;
    owner_e                   gnt_owner;
    logic [DATA_W-1:0]        sel_addr, sel_wd;
    logic                     sel_we;

    // A master whose ack is high this cycle is masked, so the IDLE cycle
    // carrying an ack can hand the bus to the other master.
    assign elig0 = m0_req & ~ack_q[0];
    assign elig1 = m1_req & ~ack_q[1];

    dev_arb_rr u_rr (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_i      (elig0),
        .req1_i      (elig1),
        .take_i      (rr_take),
        .gnt_vld_o   (gnt_vld),
        .gnt_owner_o (gnt_owner)
    );

    assign sel_addr = (gnt_owner == OWN_M0) ? m0_addr : m1_addr;
    assign sel_wd   = (gnt_owner == OWN_M0) ? m0_wd   : m1_wd;
    assign sel_we   = (gnt_owner == OWN_M0) ? m0_we   : m1_we;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        we_d      = we_q;
        bus_req_d = bus_req_q;
        bus_we_d  = bus_we_q;
        ack_d     = '0;
        err_d     = '0;
        rd_d      = '0;
        rr_take   = 1'b0;
`ifdef DEV_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    rr_take = 1'b1;
                    owner_d = gnt_owner;
                    addr_d  = sel_addr;
                    wd_d    = sel_wd;
                    we_d    = sel_we;
                    if (win_hit(sel_addr[15:4])) begin
                        state_d   = ST_BUSY;
                        bus_req_d = 1'b1;
                        bus_we_d  = sel_we;
`ifdef DEV_ARB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end else begin
                        state_d = ST_REJECT;
                    end
                end
            end

            ST_BUSY: begin
                if (bus_rdy) begin
                    // bus_rdy wins over a timeout reached in the same cycle.
                    state_d            = ST_IDLE;
                    bus_req_d          = 1'b0;
                    bus_we_d           = 1'b0;
                    ack_d[owner_q]     = 1'b1;
                    rd_d[owner_q]      = we_q ? '0 : bus_rd;
`ifdef DEV_ARB_TIMEOUT_EN
                end else if ((cnt_q + 8'd1) == TO_LIM) begin
                    state_d            = ST_IDLE;
                    bus_req_d          = 1'b0;
                    bus_we_d           = 1'b0;
                    ack_d[owner_q]     = 1'b1;
                    err_d[owner_q]     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end

            ST_REJECT: begin
                state_d        = ST_IDLE;
                ack_d[owner_q] = 1'b1;
                err_d[owner_q] = 1'b1;
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_M0;
            addr_q    <= '0;
            wd_q      <= '0;
            we_q      <= 1'b0;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            we_q      <= we_d;
            bus_req_q <= bus_req_d;
            bus_we_q  <= bus_we_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
        end
    end

`ifdef DEV_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus_req  = bus_req_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = addr_q;
    assign bus_wd   = wd_q;
    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_err   = err_q[0];
    assign m1_err   = err_q[1];
    assign m0_rd    = rd_q[0];
    assign m1_rd    = rd_q[1];

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dev_bus_arbiter
// Directed checks of dev_bus_arbiter: zero-wait read, round-robin tie,
// rejected access, long wait (or timeout with DEV_ARB_TIMEOUT_EN), async
// reset mid-transaction, and input changes while a cycle is in flight.
// ----------------------------------------------------------------------------
module tb_dev_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        bus_req, bus_we, bus_rdy;
    logic [31:0] bus_addr, bus_wd, bus_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dev_bus_arbiter #(.DATA_W(32), .TIMEOUT(15)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_wd    (m0_wd),
        .m0_we    (m0_we),
        .m0_ack   (m0_ack),
        .m0_rd    (m0_rd),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_wd    (m1_wd),
        .m1_we    (m1_we),
        .m1_ack   (m1_ack),
        .m1_rd    (m1_rd),
        .m1_err   (m1_err),
        .bus_req  (bus_req),
        .bus_addr (bus_addr),
        .bus_wd   (bus_wd),
        .bus_we   (bus_we),
        .bus_rd   (bus_rd),
        .bus_rdy  (bus_rdy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, ".bus_we"},  32'(bus_we),  32'd0);
        chk({tag, ".m0_ack"},  32'(m0_ack),  32'd0);
        chk({tag, ".m1_ack"},  32'(m1_ack),  32'd0);
        chk({tag, ".m0_err"},  32'(m0_err),  32'd0);
        chk({tag, ".m1_err"},  32'(m1_err),  32'd0);
        chk({tag, ".m0_rd"},   m0_rd,        32'd0);
        chk({tag, ".m1_rd"},   m1_rd,        32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
        bus_rdy = 0; bus_rd = 0;
        tick(); tick();

        // Reset state
        chk_idle_outs("rst");
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.bus_wd",   bus_wd,   32'd0);
        reset_n = 1'b1;
        tick();

        // 1: M0 zero-wait read
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_7F04;
        bus_rdy = 1; bus_rd = 32'hDEAD_BEEF;
        tick();
        chk("rd.bus_req",  32'(bus_req), 32'd1);
        chk("rd.bus_addr", bus_addr,     32'h0000_7F04);
        chk("rd.bus_we",   32'(bus_we),  32'd0);
        chk("rd.ack_early", 32'(m0_ack), 32'd0);
        tick();
        chk("rd.m0_ack",  32'(m0_ack),  32'd1);
        chk("rd.m0_rd",   m0_rd,        32'hDEAD_BEEF);
        chk("rd.m0_err",  32'(m0_err),  32'd0);
        chk("rd.bus_req_drop", 32'(bus_req), 32'd0);
        m0_req = 0;
        tick();
        chk_idle_outs("rd.after");

        // 2: both masters tie, fresh reset so M0 wins first
        reset_n = 1'b0; #1; reset_n = 1'b1;
        m0_req = 1; m0_we = 1; m0_addr = 32'h7F10; m0_wd = 32'h1111_2222;
        m1_req = 1; m1_we = 0; m1_addr = 32'h7F10;
        bus_rdy = 1; bus_rd = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr.bus_req", 32'(bus_req), 32'd1);
            chk("rr.bus_we",  32'(bus_we),  (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr.bus_wd",  bus_wd,       (k % 2 == 0) ? 32'h1111_2222 : 32'd0);
            chk("rr.m0_ack_busy", 32'(m0_ack), 32'd0);
            chk("rr.m1_ack_busy", 32'(m1_ack), 32'd0);
            tick();
            chk("rr.m0_ack", 32'(m0_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr.m1_ack", 32'(m1_ack), (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("rr.m1_rd",  m1_rd,       (k % 2 == 0) ? 32'd0 : 32'h1234_5678);
            chk("rr.m0_rd",  m0_rd,       32'd0);
            chk("rr.bus_req_gap", 32'(bus_req), 32'd0);
        end
        m0_req = 0; m1_req = 0;
        tick();
        chk_idle_outs("rr.after");

        // 3: M1 write outside windows -> reject
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_1000; m1_wd = 32'hAAAA_5555;
        bus_rd = 32'hFFFF_FFFF;
        tick();
        chk("rej.bus_req", 32'(bus_req), 32'd0);
        chk("rej.ack_early", 32'(m1_ack), 32'd0);
        tick();
        chk("rej.m1_ack", 32'(m1_ack), 32'd1);
        chk("rej.m1_err", 32'(m1_err), 32'd1);
        chk("rej.m1_rd",  m1_rd,       32'd0);
        chk("rej.bus_req2", 32'(bus_req), 32'd0);
        chk("rej.bus_we",   32'(bus_we),  32'd0);
        m1_req = 0;
        tick();
        chk_idle_outs("rej.after");

        // 4: M0 write with bus_rdy low; inputs changed mid-BUSY
        bus_rdy = 0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h7F00; m0_wd = 32'h0BAD_CAFE;
        tick();
        chk("wait.bus_req", 32'(bus_req), 32'd1);
        chk("wait.bus_we",  32'(bus_we),  32'd1);
        m0_req = 0; m0_addr = 32'h0000_1234; m0_wd = 32'h0; m0_we = 0;
`ifdef DEV_ARB_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("to.bus_req",  32'(bus_req), 32'd1);
            chk("to.bus_addr", bus_addr,     32'h7F00);
            chk("to.m0_ack",   32'(m0_ack),  32'd0);
        end
        tick();
        chk("to.ack",     32'(m0_ack),  32'd1);
        chk("to.err",     32'(m0_err),  32'd1);
        chk("to.rd",      m0_rd,        32'd0);
        chk("to.bus_req_drop", 32'(bus_req), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wait.bus_req",  32'(bus_req), 32'd1);
            chk("wait.bus_addr", bus_addr,     32'h7F00);
            chk("wait.bus_wd",   bus_wd,       32'h0BAD_CAFE);
            chk("wait.m0_ack",   32'(m0_ack),  32'd0);
        end
        bus_rdy = 1;
        tick();
        chk("wait.ack", 32'(m0_ack), 32'd1);
        chk("wait.err", 32'(m0_err), 32'd0);
        chk("wait.rd",  m0_rd,       32'd0);
        chk("wait.bus_req_drop", 32'(bus_req), 32'd0);
        bus_rdy = 0;
`endif
        tick();
        chk_idle_outs("wait.after");

        // 5: async reset during BUSY, then pending M1 completes
        m0_req = 1; m0_we = 0; m0_addr = 32'h7F08;
        tick();
        chk("rst5.bus_req", 32'(bus_req), 32'd1);
        m1_req = 1; m1_we = 0; m1_addr = 32'h7F14;
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outs("rst5.mid");
        chk("rst5.bus_addr", bus_addr, 32'd0);
        m0_req = 0;
        tick();
        reset_n = 1'b1;
        bus_rdy = 1; bus_rd = 32'hCAFE_F00D;
        tick();
        chk("rst5.m1_bus_req", 32'(bus_req), 32'd1);
        chk("rst5.m1_addr",    bus_addr,     32'h7F14);
        tick();
        chk("rst5.m1_ack", 32'(m1_ack), 32'd1);
        chk("rst5.m1_rd",  m1_rd,       32'hCAFE_F00D);
        chk("rst5.m1_err", 32'(m1_err), 32'd0);
        chk("rst5.m0_ack", 32'(m0_ack), 32'd0);
        m1_req = 0;
        tick();
        chk_idle_outs("rst5.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
